// File: rtl/muldiv_unit_pkg.sv
// Shared constants, FSM/step encodings and funct3 op-class decode for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam int MDU_XLEN  = 32;
    localparam int MDU_CNT_W = 5;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    typedef struct packed {
        logic is_div;
        logic signed_a;
        logic signed_b;
        logic want_high;
        logic want_rem;
    } op_class_t;

    function automatic op_class_t decode_op(input logic [2:0] funct3);
        op_class_t c;
        c.is_div    = funct3[2];
        c.signed_a  = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV) || (funct3 == F3_REM);
        c.signed_b  = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                      (funct3 == F3_DIV) || (funct3 == F3_REM);
        c.want_high = !funct3[2] && (funct3 != F3_MUL);
        c.want_rem  = funct3[2] && funct3[1];
        return c;
    endfunction

endpackage

// File: rtl/muldiv_unit_mdu_step.sv
// One radix-2 iteration: shift-add for multiply, trial subtract for restoring divide.
module muldiv_unit_mdu_step
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] operand,
    input  step_mode_e      mode,
    input  logic            bit_in,
    output logic [XLEN-1:0] acc_next,
    output logic            bit_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;

    always_comb begin
        sum      = '0;
        shifted  = '0;
        acc_next = acc;
        bit_out  = 1'b0;
        if (mode == STEP_MUL) begin
            // bit_in is the multiplier LSB; the carry-out lands in the accumulator MSB
            sum      = {1'b0, acc} + (bit_in ? {1'b0, operand} : '0);
            acc_next = sum[XLEN:1];
            bit_out  = sum[0];
        end else begin
            // bit_in is the next dividend bit shifted into the partial remainder
            shifted = {acc, bit_in};
            if (shifted >= {1'b0, operand}) begin
                acc_next = shifted[XLEN-1:0] - operand;
                bit_out  = 1'b1;
            end else begin
                acc_next = shifted[XLEN-1:0];
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide responder: one op in flight, req/resp handshakes, flush abort.
//
//  state  | meaning
//  S_IDLE | ready for a request (req_ready=1)
//  S_CALC | iterating one step per cycle, counter counts down to terminal count 0
//  S_DONE | result held on resp_result with resp_valid=1 until resp_ready
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    localparam logic [XLEN-1:0]  WORD_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(XLEN-1);

    state_e          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    op_class_t       cls;
    logic            msb_a;
    logic            msb_b;

    op_class_t       in_cls;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic            is_fast;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        in_cls   = decode_op(req_funct3);
        sign_a   = in_cls.signed_a & req_rs1[XLEN-1];
        sign_b   = in_cls.signed_b & req_rs2[XLEN-1];
        mag_a    = sign_a ? ('0 - req_rs1) : req_rs1;
        mag_b    = sign_b ? ('0 - req_rs2) : req_rs2;
        div_zero = in_cls.is_div & (req_rs2 == '0);
        div_ovf  = in_cls.is_div & in_cls.signed_a & (req_rs1 == WORD_MIN) & (req_rs2 == '1);
        is_fast  = div_zero | div_ovf;
        if (div_zero) begin
            fast_result = in_cls.want_rem ? req_rs1 : '1;
        end else begin
            fast_result = in_cls.want_rem ? '0 : WORD_MIN;
        end
    end

    step_mode_e      step_mode;
    logic            step_in;
    logic [XLEN-1:0] step_acc;
    logic            step_bit;

    assign step_mode = cls.is_div ? STEP_DIV : STEP_MUL;
    assign step_in   = cls.is_div ? lo[XLEN-1] : lo[0];

    muldiv_unit_mdu_step #(
        .XLEN(XLEN)
    ) u_step (
        .acc      (acc),
        .operand  (opnd),
        .mode     (step_mode),
        .bit_in   (step_in),
        .acc_next (step_acc),
        .bit_out  (step_bit)
    );

    logic [XLEN-1:0]   lo_next;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_res;
    logic [XLEN-1:0]   quot_res;
    logic [XLEN-1:0]   rem_res;
    logic [XLEN-1:0]   final_result;

    // Signs are applied only on the last step, so the loop works on magnitudes throughout
    always_comb begin
        lo_next  = cls.is_div ? {lo[XLEN-2:0], step_bit} : {step_bit, lo[XLEN-1:1]};
        neg_r    = cls.signed_a & msb_a;
        neg_q    = neg_r ^ (cls.signed_b & msb_b);
        prod_mag = {step_acc, lo_next};
        prod_res = neg_q ? ('0 - prod_mag) : prod_mag;
        quot_res = neg_q ? ('0 - lo_next) : lo_next;
        rem_res  = neg_r ? ('0 - step_acc) : step_acc;
        if (cls.want_rem) begin
            final_result = rem_res;
        end else if (cls.is_div) begin
            final_result = quot_res;
        end else if (cls.want_high) begin
            final_result = prod_res[2*XLEN-1:XLEN];
        end else begin
            final_result = prod_res[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            busy        <= 1'b0;
            resp_result <= '0;
            cnt         <= '0;
            acc         <= '0;
            lo          <= '0;
            opnd        <= '0;
            cls         <= '0;
            msb_a       <= 1'b0;
            msb_b       <= 1'b0;
        end else if (flush) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        cls       <= in_cls;
                        msb_a     <= req_rs1[XLEN-1];
                        msb_b     <= req_rs2[XLEN-1];
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (is_fast) begin
                            resp_result <= fast_result;
                            resp_valid  <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            acc   <= '0;
                            lo    <= in_cls.is_div ? mag_a : mag_b;
                            opnd  <= in_cls.is_div ? mag_b : mag_a;
                            cnt   <= CNT_LOAD;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= step_acc;
                    lo  <= lo_next;
                    if (cnt == '0) begin
                        resp_result <= final_result;
                        resp_valid  <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected results queued at request time, compared at response.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] p;
        logic [63:0]        pu;
        logic [31:0]        r;
        logic               ovf;
        ea  = {{32{a[31]}}, a};
        eb  = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f3)
            3'd0: begin p = ea * eb; r = p[31:0]; end
            3'd1: begin p = ea * eb; r = p[63:32]; end
            3'd2: begin p = ea * $signed({32'b0, b}); r = p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        sb_q.push_back(exp);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat, output bit rdy_seen);
        lat      = 1;
        rdy_seen = 1'b0;
        @(negedge clk);
        while (!resp_valid && lat < 100) begin
            if (req_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (req_ready) rdy_seen = 1'b1;
    endtask

    task automatic take();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_result !== 32'h0) begin errors++; $display("FAIL reset_resp_result: got %h want 0", resp_result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat; bit rs; logic [31:0] exp;
        send(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        wait_resp(lat, rs);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mul_req_ready_low: got %b want 0", rs); end
        exp = sb_q.pop_front();
        checks++; if (resp_result !== exp) begin errors++; $display("FAIL mul_result: got %h want %h", resp_result, exp); end
        take();
    endtask

    task automatic test_mulh();
        int lat; bit rs; logic [31:0] exp;
        logic [2:0]  ops  [3] = '{3'd1, 3'd2, 3'd3};
        logic [31:0] exps [3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        for (int i = 0; i < 3; i++) begin
            send(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, exps[i]);
            wait_resp(lat, rs);
            exp = sb_q.pop_front();
            checks++; if (resp_result !== exp) begin errors++; $display("FAIL mulh_f3_%0d: got %h want %h", ops[i], resp_result, exp); end
            take();
        end
    endtask

    task automatic test_div();
        int lat; bit rs; logic [31:0] exp;
        logic [2:0]  ops  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exps [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            send(ops[i], as[i], bs[i], exps[i]);
            wait_resp(lat, rs);
            checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency_%0d: got %0d want 33", i, lat); end
            exp = sb_q.pop_front();
            checks++; if (resp_result !== exp) begin errors++; $display("FAIL div_result_%0d: got %h want %h", i, resp_result, exp); end
            take();
        end
    endtask

    task automatic test_fast_path();
        int lat; bit rs; logic [31:0] exp;
        logic [2:0]  ops  [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            send(ops[i], as[i], bs[i], exps[i]);
            wait_resp(lat, rs);
            checks++; if (lat !== 1) begin errors++; $display("FAIL fast_latency_%0d: got %0d want 1", i, lat); end
            exp = sb_q.pop_front();
            checks++; if (resp_result !== exp) begin errors++; $display("FAIL fast_result_%0d: got %h want %h", i, resp_result, exp); end
            take();
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit rs; logic [31:0] exp;
        send(3'd0, 32'd5, 32'd6, 32'd30);
        wait_resp(lat, rs);
        exp = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_result !== exp || resp_valid !== 1'b1) begin
                errors++; $display("FAIL hold_stable_%0d: got %h valid %b want %h valid 1", i, resp_result, resp_valid, exp);
            end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready_%0d: got %b want 0", i, req_ready); end
            @(negedge clk);
        end
        // request already pending while the response handshake happens
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_funct3 = 3'd5;
        req_rs1    = 32'd100;
        req_rs2    = 32'd7;
        sb_q.push_back(32'd14);
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_no_same_cycle: got ready %b busy %b want ready 1 busy 0", req_ready, busy);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat, rs);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        exp = sb_q.pop_front();
        checks++; if (resp_result !== exp) begin errors++; $display("FAIL b2b_result: got %h want %h", resp_result, exp); end
        take();
    endtask

    task automatic test_flush();
        bit seen;
        send(3'd0, 32'd9, 32'd9, 32'd81);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got ready %b busy %b valid %b want 1 0 0", req_ready, busy, resp_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_resp: got resp_valid 1 want 0"); end
        req_valid  = 1'b1;
        flush      = 1'b1;
        req_funct3 = 3'd5;
        req_rs1    = 32'd10;
        req_rs2    = 32'd3;
        @(posedge clk);
        #1 begin req_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL flush_blocks_accept: got busy %b ready %b want 0 1", busy, req_ready);
        end
    endtask

    task automatic test_rst_mid_calc();
        int lat; bit rs; logic [31:0] exp;
        send(3'd0, 32'd123, 32'd456, 32'd56088);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 || resp_result !== 32'h0) begin
            errors++; $display("FAIL rst_mid_calc: got ready %b valid %b busy %b result %h want 1 0 0 0",
                               req_ready, resp_valid, busy, resp_result);
        end
        send(3'd0, 32'd3, 32'd4, 32'd12);
        wait_resp(lat, rs);
        checks++; if (lat !== 33) begin errors++; $display("FAIL rst_mul_latency: got %0d want 33", lat); end
        exp = sb_q.pop_front();
        checks++; if (resp_result !== exp) begin errors++; $display("FAIL rst_mul_result: got %h want %h", resp_result, exp); end
        take();
    endtask

    task automatic test_random();
        int lat; bit rs; logic [31:0] exp;
        logic [2:0] f3; logic [31:0] a; logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'(i % 8);
            a  = $urandom;
            b  = $urandom;
            if (i % 5 == 1) b = 32'($urandom_range(0, 9));
            if (i % 7 == 3) a = 32'h8000_0000;
            send(f3, a, b, ref_result(f3, a, b));
            wait_resp(lat, rs);
            checks++; if (lat !== ref_latency(f3, a, b)) begin
                errors++; $display("FAIL rand_latency_%0d: got %0d want %0d", i, lat, ref_latency(f3, a, b));
            end
            exp = sb_q.pop_front();
            checks++; if (resp_result !== exp) begin
                errors++; $display("FAIL rand_result_%0d: f3 %0d a %h b %h got %h want %h", i, f3, a, b, resp_result, exp);
            end
            take();
        end
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_funct3 = 3'd0;
        req_rs1    = '0;
        req_rs2    = '0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_flush();
        test_rst_mid_calc();
        test_random();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
